lcd_frame_writer: RTL and testbench
===================================

# lcd_frame_writer

Parametrised character-LCD frame sequencer for HD44780-class displays. It takes a full ROWS×COLS character frame and an optional init request, then emits the byte stream (commands and characters) one byte at a time to the downstream nibble/bus writer. Each byte uses an ena_write/done_write handshake, followed by a per-byte settle delay. It sits between the application (status/temperature text formatting) and the LCD bus writer. It adds latched frames, a long clear delay, ack timeout and a completion pulse.

## Interface
- ROWS, 2, display rows (1–4)
- COLS, 16, characters per row (8–20)
- CMD_DELAY_US, 50, settle delay after every byte except clear, in clk_1MHz cycles
- CLR_DELAY_US, 1640, settle delay after clear-display (0x01)
- ACK_TIMEOUT_US, 1000, maximum wait for done_write before abort
- clk_1MHz  in  1  1 MHz clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a frame write; sampled only in IDLE
- init_req  in  1  sampled with start; 1 = prepend init sequence
- frame  in  ROWS*COLS*8  characters, MSB-first: char(r,c) = frame[ROWS*COLS*8-1-8*(r*COLS+c) -: 8]
- done_write  in  1  downstream byte-complete pulse
- data  out  8  byte to write
- cmd_data  out  1  0 = command, 1 = character data
- ena_write  out  1  one-cycle write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky ack-timeout flag; cleared by the next accepted start

## Operation
- States: IDLE, LOAD, WRITE, WAIT_ACK, DELAY, DONE.
- IDLE → LOAD when start=1. The transition latches init_req and clears error.
- LOAD: copies frame into a shadow register. Byte index goes to 0. Later changes on frame are ignored until the next start.
- Byte list (N = (init?5:0) + ROWS*(1+COLS)):
  - Init bytes when init_req is latched: 0x02, 0x28, 0x0C, 0x06, 0x01, all commands.
  - Then, per row r=0..ROWS-1: command 0x80|base[r], followed by COLS character bytes char(r,0..COLS-1).
  - base = {0x00, 0x40, COLS, 0x40+COLS}.
- WRITE: registers data and cmd_data, pulses ena_write for 1 cycle, then goes to WAIT_ACK.
- WAIT_ACK: waits for done_write=1, then goes to DELAY.
  - If the timeout counter reaches ACK_TIMEOUT_US-1 first: error←1, go to IDLE. No done pulse.
- DELAY: counts D cycles, where D = CLR_DELAY_US for byte 0x01 in the init section and CMD_DELAY_US otherwise.
  - At count D-1: if index = N-1, go to DONE; else index+1 and go to WRITE.
  - The last byte also gets its full delay.
- DONE: done=1 for one cycle, then IDLE.
- A single cycle counter, width $clog2(max(CLR_DELAY_US, ACK_TIMEOUT_US)+1), clears on every state entry.
- Ignored inputs:
  - start while busy.
  - done_write outside WAIT_ACK.
  - done_write coinciding with the timeout terminal count counts as success, not as an error.

## Timing
- Reset values: data=0x00, cmd_data=0, ena_write=0, busy=0, done=0, error=0, state=IDLE, index=0. Reset acts immediately mid-frame and abandons the sequence; no cleanup bytes are sent.
- start sampled at edge 0 → busy high after edge 0 → LOAD.
  - First ena_write is high for the cycle after edge 2.
  - data and cmd_data are valid in that same cycle and held until the next WRITE.
- done_write sampled at edge k → next ena_write asserted after edge k+D+1.
- Frame duration with a 1-cycle ack: 2 + Σ(D_i + 3) cycles + 1 DONE cycle.
- done pulses exactly once per successful frame. busy falls the cycle after done.

## Test plan
- ROWS=2, COLS=16, init_req=1, bench acks 2 cycles after each strobe:
  - Expect exactly 39 strobes in order: 0x02, 0x28, 0x0C, 0x06, 0x01, 0x80, 16 chars, 0xC0, 16 chars.
  - cmd_data=0 on the 7 command bytes, 1 on the 32 characters.
  - One done pulse.
- Measure the strobe gap. After 0x01, the gap from done_write to the next strobe is 1641 cycles. After other bytes it is 51 cycles. After the final character, done follows 51 cycles after ack.
- init_req=0, frame = "COLD ROOM  -18C " / "DOOR OK         ": 34 strobes starting 0x80, 'C' (0x43). Change frame mid-write; the output still matches the latched frame.
- Bench never asserts done_write on the 3rd byte: after 1000 cycles, error=1, busy=0, no done. A new start clears error and completes normally.
- ROWS=4, COLS=20: row commands are 0x80, 0xC0, 0x94, 0xD4; 84 bytes total without init.
- Pulse rst_n low during the 10th byte's DELAY: all outputs return to reset values at once. Restarting start begins again from byte 0. A spurious done_write in IDLE and a start while busy both have no effect.

Source files
------------

// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: streams an optional HD44780 init sequence plus a latched
// ROWS x COLS character frame, one handshaked byte at a time.
module lcd_frame_writer #(
    parameter int ROWS           = 2,
    parameter int COLS           = 16,
    parameter int CMD_DELAY_US   = 50,
    parameter int CLR_DELAY_US   = 1640,
    parameter int ACK_TIMEOUT_US = 1000
) (
    input  logic                     clk_1MHz,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     init_req,
    input  logic [ROWS*COLS*8-1:0]   frame,
    input  logic                     done_write,
    output logic [7:0]               data,
    output logic                     cmd_data,
    output logic                     ena_write,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int FW   = ROWS * COLS * 8;
    localparam int NCH  = ROWS * COLS;
    localparam int PW   = $clog2(NCH);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = $clog2(COLS + 1);
    localparam int NB   = 5 + ROWS * (COLS + 1);
    localparam int IW   = $clog2(NB + 1);
    localparam int MAXD = (CLR_DELAY_US > ACK_TIMEOUT_US) ? CLR_DELAY_US : ACK_TIMEOUT_US;
    localparam int TW   = $clog2(MAXD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_WAIT_ACK,
        S_DELAY,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            init_q, init_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            cmd_data_q, cmd_data_d;
    logic            ena_write_q, ena_write_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic [7:0]      chars [NCH];
    logic [PW-1:0]   pos;
    logic [7:0]      base;
    logic [7:0]      init_byte;
    logic [7:0]      cur_byte;
    logic            cur_is_char;
    logic            in_init;
    logic            is_clr;
    logic            is_last;
    logic [TW-1:0]   dly_last;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            chars[i] = frame_q[FW-1-8*i -: 8];
        end
    end

    // col_q == 0 selects the row's DDRAM address command, 1..COLS the characters
    always_comb begin
        in_init = init_q && (idx_q < IW'(5));
        is_clr  = in_init && (idx_q == IW'(4));
        is_last = !in_init && (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS));
        pos     = PW'(PW'(row_q) * PW'(COLS) + PW'(col_q) - PW'(1));
        base    = 8'h00;
        if (int'(row_q) == 1) begin
            base = 8'h40;
        end else if (int'(row_q) == 2) begin
            base = 8'(COLS);
        end else if (int'(row_q) == 3) begin
            base = 8'(64 + COLS);
        end
        case (idx_q[2:0])
            3'd0:    init_byte = 8'h02;
            3'd1:    init_byte = 8'h28;
            3'd2:    init_byte = 8'h0C;
            3'd3:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
        if (in_init) begin
            cur_byte    = init_byte;
            cur_is_char = 1'b0;
        end else if (col_q == '0) begin
            cur_byte    = 8'h80 | base;
            cur_is_char = 1'b0;
        end else begin
            cur_byte    = chars[pos];
            cur_is_char = 1'b1;
        end
        dly_last = is_clr ? TW'(CLR_DELAY_US - 1) : TW'(CMD_DELAY_US - 1);
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        init_d      = init_q;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        cmd_data_d  = cmd_data_q;
        ena_write_d = 1'b0;
        done_d      = 1'b0;
        error_d     = error_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    state_d = S_LOAD;
                    init_d  = init_req;
                    error_d = 1'b0;
                end
            end
            S_LOAD: begin
                frame_d = frame;
                idx_d   = '0;
                row_d   = '0;
                col_d   = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                data_d      = cur_byte;
                cmd_data_d  = cur_is_char;
                ena_write_d = 1'b1;
                state_d     = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (done_write) begin
                    state_d = S_DELAY;
                end else if (cnt_q == TW'(ACK_TIMEOUT_US - 1)) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DELAY: begin
                if (cnt_q == dly_last) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_WRITE;
                        if (!in_init) begin
                            if (col_q == CW'(COLS)) begin
                                col_d = '0;
                                row_d = row_q + RW'(1);
                            end else begin
                                col_d = col_q + CW'(1);
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        // hold busy through the done pulse so it drops the cycle after
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            init_q      <= 1'b0;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            data_q      <= 8'h00;
            cmd_data_q  <= 1'b0;
            ena_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            init_q      <= init_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            cmd_data_q  <= cmd_data_d;
            ena_write_q <= ena_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign data      = data_q;
    assign cmd_data  = cmd_data_q;
    assign ena_write = ena_write_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Randomized self-checking bench for lcd_frame_writer (2x16 and 4x20).
`timescale 1ns/1ps
module tb_lcd_frame_writer;

    logic         clk_1MHz = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         init_req = 1'b0;
    logic         done_write = 1'b0;
    logic         sel = 1'b0;
    logic [255:0] frame2 = '0;
    logic [639:0] frame4 = '0;

    logic [7:0] d2_data, d4_data;
    logic       d2_cmd, d4_cmd, d2_ena, d4_ena, d2_busy, d4_busy;
    logic       d2_done, d4_done, d2_err, d4_err;

    logic [7:0] o_data;
    logic       o_cmd, o_ena, o_busy, o_done, o_error;

    always #500 clk_1MHz = ~clk_1MHz;

    int cyc = 0;
    always @(posedge clk_1MHz) cyc <= cyc + 1;

    lcd_frame_writer dut2 (
        .clk_1MHz  (clk_1MHz),
        .rst_n     (rst_n),
        .start     (start & ~sel),
        .init_req  (init_req),
        .frame     (frame2),
        .done_write(done_write & ~sel),
        .data      (d2_data),
        .cmd_data  (d2_cmd),
        .ena_write (d2_ena),
        .busy      (d2_busy),
        .done      (d2_done),
        .error     (d2_err)
    );

    lcd_frame_writer #(
        .ROWS(4), .COLS(20), .CMD_DELAY_US(4), .CLR_DELAY_US(9), .ACK_TIMEOUT_US(20)
    ) dut4 (
        .clk_1MHz  (clk_1MHz),
        .rst_n     (rst_n),
        .start     (start & sel),
        .init_req  (init_req),
        .frame     (frame4),
        .done_write(done_write & sel),
        .data      (d4_data),
        .cmd_data  (d4_cmd),
        .ena_write (d4_ena),
        .busy      (d4_busy),
        .done      (d4_done),
        .error     (d4_err)
    );

    assign o_data  = sel ? d4_data : d2_data;
    assign o_cmd   = sel ? d4_cmd  : d2_cmd;
    assign o_ena   = sel ? d4_ena  : d2_ena;
    assign o_busy  = sel ? d4_busy : d2_busy;
    assign o_done  = sel ? d4_done : d2_done;
    assign o_error = sel ? d4_err  : d2_err;

    int rows, cols, cmdd, clrd, ack_to;
    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] e_data[$];
    logic       e_cmd[$];
    int         e_dly[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [639:0] rnd();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_frame(input logic [639:0] f);
        if (sel) frame4 = f;
        else frame2 = f[255:0];
    endtask

    // expected byte stream from the display's addressing rules
    task automatic build(input logic [639:0] f, input bit init);
        logic [7:0]   ib[5] = '{8'h02, 8'h28, 8'h0C, 8'h06, 8'h01};
        int           base[4];
        logic [639:0] t;
        base = '{0, 64, cols, 64 + cols};
        e_data.delete();
        e_cmd.delete();
        e_dly.delete();
        if (init) begin
            for (int k = 0; k < 5; k++) begin
                e_data.push_back(ib[k]);
                e_cmd.push_back(1'b0);
                e_dly.push_back(ib[k] == 8'h01 ? clrd : cmdd);
            end
        end
        for (int r = 0; r < rows; r++) begin
            e_data.push_back(8'h80 | 8'(base[r]));
            e_cmd.push_back(1'b0);
            e_dly.push_back(cmdd);
            for (int c = 0; c < cols; c++) begin
                t = f >> (rows * cols * 8 - 8 - 8 * (r * cols + c));
                e_data.push_back(t[7:0]);
                e_cmd.push_back(1'b1);
                e_dly.push_back(cmdd);
            end
        end
    endtask

    task automatic run_frame(input logic [639:0] f, input bit init, input int drop,
                             input int chg, input int rst_at, input int poke);
        int got, ack_pend, ack_cyc, strobe_cyc, c0, n_exp;
        bit fin, dn;
        build(f, init);
        n_exp = e_data.size();
        got = 0; ack_pend = -1; ack_cyc = -1; strobe_cyc = 0; fin = 0;
        @(negedge clk_1MHz);
        set_frame(f);
        init_req = init;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk_1MHz);
        start = 1'b0;
        check("busy_after_start", 32'(o_busy), 1);
        check("error_cleared", 32'(o_error), 0);
        for (int i = 0; i < 20000 && !fin; i++) begin
            done_write = 1'b0;
            start = 1'b0;
            if (o_ena) begin
                if (got == 0) check("first_strobe_latency", cyc - c0, 3);
                if (got < n_exp) begin
                    check($sformatf("data[%0d]", got), 32'(o_data), 32'(e_data[got]));
                    check($sformatf("cmd_data[%0d]", got), 32'(o_cmd), 32'(e_cmd[got]));
                    if (got > 0)
                        check($sformatf("gap[%0d]", got), cyc - ack_cyc - 1, e_dly[got-1] + 1);
                end else begin
                    check("extra_strobe", got, n_exp);
                end
                if (got == chg) set_frame(rnd());
                if (got == poke) begin
                    start = 1'b1;
                    init_req = ~init;
                end
                ack_pend = (got == drop) ? -1 : cyc + 2;
                strobe_cyc = cyc;
                got++;
            end
            if (ack_pend >= 0 && cyc == ack_pend) begin
                done_write = 1'b1;
                ack_cyc = cyc;
                ack_pend = -1;
            end
            if (rst_at >= 0 && got == rst_at + 1 && ack_pend < 0 &&
                ack_cyc > strobe_cyc && cyc == ack_cyc + 5) begin
                rst_n = 1'b0;
                done_write = 1'b0;
                #1;
                check("rst_data", 32'(o_data), 0);
                check("rst_cmd_data", 32'(o_cmd), 0);
                check("rst_ena_write", 32'(o_ena), 0);
                check("rst_busy", 32'(o_busy), 0);
                check("rst_done", 32'(o_done), 0);
                check("rst_error", 32'(o_error), 0);
                @(negedge clk_1MHz);
                rst_n = 1'b1;
                fin = 1;
            end else if (o_done) begin
                check("done_byte_count", got, n_exp);
                check("done_gap", cyc - ack_cyc - 1, e_dly[n_exp-1] + 1);
                check("busy_with_done", 32'(o_busy), 1);
                @(negedge clk_1MHz);
                check("busy_after_done", 32'(o_busy), 0);
                check("done_one_cycle", 32'(o_done), 0);
                fin = 1;
            end else if (o_error) begin
                check("error_byte_count", got, drop + 1);
                check("timeout_length", cyc - strobe_cyc, ack_to);
                check("busy_on_error", 32'(o_busy), 0);
                dn = 0;
                repeat (5) begin
                    @(negedge clk_1MHz);
                    dn |= o_done | o_ena;
                end
                check("quiet_after_error", 32'(dn), 0);
                check("error_sticky", 32'(o_error), 1);
                fin = 1;
            end
            if (!fin) @(negedge clk_1MHz);
        end
        if (!fin) check("frame_timeout", 0, 1);
    endtask

    initial begin
        logic [255:0] txt;
        bit seen;
        txt = {"COLD ROOM  -18C ", "DOOR OK         "};
        rows = 2; cols = 16; cmdd = 50; clrd = 1640; ack_to = 1000;
        repeat (2) @(negedge clk_1MHz);
        check("reset_data", 32'(o_data), 0);
        check("reset_cmd_data", 32'(o_cmd), 0);
        check("reset_ena_write", 32'(o_ena), 0);
        check("reset_busy", 32'(o_busy), 0);
        check("reset_done", 32'(o_done), 0);
        check("reset_error", 32'(o_error), 0);
        rst_n = 1'b1;
        @(negedge clk_1MHz);

        run_frame(rnd(), 1'b1, -1, -1, -1, 7);
        run_frame({384'b0, txt}, 1'b0, -1, 10, -1, -1);
        run_frame(rnd(), 1'b1, 2, -1, -1, -1);
        run_frame(rnd(), 1'b1, -1, -1, -1, -1);
        run_frame(rnd(), 1'b1, -1, -1, 9, -1);
        run_frame(rnd(), 1'b0, -1, -1, -1, 3);

        @(negedge clk_1MHz);
        done_write = 1'b1;
        @(negedge clk_1MHz);
        done_write = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk_1MHz);
            seen |= o_ena | o_busy | o_done;
        end
        check("idle_ignores_done_write", 32'(seen), 0);

        sel = 1'b1;
        rows = 4; cols = 20; cmdd = 4; clrd = 9; ack_to = 20;
        run_frame(rnd(), 1'b0, -1, 30, -1, 40);
        run_frame(rnd(), 1'b1, 6, -1, -1, -1);
        run_frame(rnd(), 1'b1, -1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
